// File: rtl/alu_result_writeback_pkg.sv
// alu_result_writeback_pkg
//   Shared definitions for the ALU result writeback stage: the ALU opcode
//   map, the bus-beat destination tags and the writeback FSM state encoding.
package alu_result_writeback_pkg;

  // ALU opcode map. Only MUL and DIV produce a 64-bit result; every other
  // opcode (including unlisted encodings) retires as a single word.
  localparam logic [4:0] ALU_OP_NOP  = 5'b00000;
  localparam logic [4:0] ALU_OP_LDW  = 5'b00001;
  localparam logic [4:0] ALU_OP_STW  = 5'b00010;
  localparam logic [4:0] ALU_OP_ADD  = 5'b00011;
  localparam logic [4:0] ALU_OP_ADDI = 5'b00100;
  localparam logic [4:0] ALU_OP_SUB  = 5'b00101;
  localparam logic [4:0] ALU_OP_AND  = 5'b00110;
  localparam logic [4:0] ALU_OP_OR   = 5'b00111;
  localparam logic [4:0] ALU_OP_XOR  = 5'b01000;
  localparam logic [4:0] ALU_OP_SLL  = 5'b01001;
  localparam logic [4:0] ALU_OP_SRL  = 5'b01010;
  localparam logic [4:0] ALU_OP_SRA  = 5'b01011;
  localparam logic [4:0] ALU_OP_SLT  = 5'b01100;
  localparam logic [4:0] ALU_OP_SLTU = 5'b01101;
  localparam logic [4:0] ALU_OP_NOR  = 5'b01110;
  localparam logic [4:0] ALU_OP_MUL  = 5'b01111;
  localparam logic [4:0] ALU_OP_DIV  = 5'b10000;

  // Destination of a bus beat.
  typedef enum logic [1:0] {
    TAG_RZ = 2'b00,  // general register
    TAG_LO = 2'b01,  // LO (low word / quotient)
    TAG_HI = 2'b10   // HI (high word / remainder)
  } tag_e;

  // Writeback FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // nothing held
    ST_ONE  = 2'b01,  // single-word beat presented
    ST_LO   = 2'b10,  // first beat of a 64-bit result presented
    ST_HI   = 2'b11   // second beat of a 64-bit result presented
  } state_e;

endpackage

// File: rtl/alu_result_writeback_if.sv
// alu_result_writeback_if
//   Handshake bundle around the writeback stage.
//   Input side : in_valid/in_ready with opcode and 64-bit Z from the ALU.
//   Output side: out_valid/out_ready with a DATA_W payload and a 2-bit tag.
//   slave  : view of the writeback stage itself.
//   master : view of the surrounding environment (ALU + bus consumer).
interface alu_result_writeback_if #(
  parameter int DATA_W = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            opcode;
  logic [2*DATA_W-1:0]   Z;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_data;
  logic [1:0]            out_tag;

  modport slave (
    input  in_valid, opcode, Z, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, opcode, Z, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/alu_result_writeback.sv
// alu_result_writeback
//   Captures the ALU's 64-bit Z result and retires it onto the 32-bit
//   datapath bus. Single-word ops take one beat (tag RZ); MUL/DIV take two
//   beats (LO then HI) and update the architectural HI/LO registers.
// Ports:
//   clock       : system clock, rising edge
//   clear       : asynchronous active-low reset
//   bus         : handshake bundle (slave view), see alu_result_writeback_if
//   hi_q, lo_q  : architectural HI/LO registers
//   upper_err   : sticky, a single-word op arrived with nonzero Z upper half
//   retired_cnt : count of fully retired operations (wraps)
module alu_result_writeback
  import alu_result_writeback_pkg::*;
#(
  parameter int         DATA_W = 32,
  parameter int         CNT_W  = 16,
  parameter logic [4:0] OP_MUL = ALU_OP_MUL,
  parameter logic [4:0] OP_DIV = ALU_OP_DIV
) (
  input  logic                 clock,
  input  logic                 clear,
  alu_result_writeback_if.slave bus,
  output logic [DATA_W-1:0]    hi_q,
  output logic [DATA_W-1:0]    lo_q,
  output logic                 upper_err,
  output logic [CNT_W-1:0]     retired_cnt
);

  state_e                state_reg;
  state_e                state_next;
  logic [2*DATA_W-1:0]   z_reg;
  logic                  out_valid_reg;
  logic                  out_valid_next;
  logic [DATA_W-1:0]     out_data_reg;
  logic [DATA_W-1:0]     out_data_next;
  tag_e                  out_tag_reg;
  tag_e                  out_tag_next;

  logic accept;
  logic beat_done;
  logic new_wide;
  logic final_beat;

  assign new_wide = (bus.opcode == OP_MUL) || (bus.opcode == OP_DIV);

  // A new result can enter when nothing is held, or when the beat being
  // presented is the last one of its op and is leaving this cycle. This is
  // combinational from out_ready so single-word ops stream at one per cycle.
  assign bus.in_ready = (state_reg == ST_IDLE) ||
                        (((state_reg == ST_ONE) || (state_reg == ST_HI)) && bus.out_ready);

  assign accept     = bus.in_valid & bus.in_ready;
  assign beat_done  = out_valid_reg & bus.out_ready;
  assign final_beat = beat_done && ((state_reg == ST_ONE) || (state_reg == ST_HI));

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_tag   = out_tag_reg;

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. An accept always wins: it can only happen from IDLE or
  // alongside the final beat's handshake, so the old op is already done.
  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = new_wide ? ST_LO : ST_ONE;
    end else if (beat_done) begin
      state_next = (state_reg == ST_LO) ? ST_HI : ST_IDLE;
    end
  end

  // Output logic: the next beat to present, registered below so the bus
  // sees glitch-free values that hold steady while stalled.
  always_comb begin
    out_valid_next = (state_next != ST_IDLE);
    out_data_next  = out_data_reg;
    out_tag_next   = out_tag_reg;
    if (accept) begin
      out_data_next = bus.Z[DATA_W-1:0];
      out_tag_next  = new_wide ? TAG_LO : TAG_RZ;
    end else if (beat_done && (state_reg == ST_LO)) begin
      out_data_next = z_reg[2*DATA_W-1:DATA_W];
      out_tag_next  = TAG_HI;
    end
  end

  // Beat registers, captured result and architectural/debug state.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_tag_reg   <= TAG_RZ;
      z_reg         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      upper_err     <= 1'b0;
      retired_cnt   <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_tag_reg   <= out_tag_next;

      if (accept) begin
        z_reg <= bus.Z;
        if (!new_wide && (bus.Z[2*DATA_W-1:DATA_W] != '0)) begin
          upper_err <= 1'b1;
        end
      end

      // HI/LO take the held result's halves as each beat is accepted; z_reg
      // still holds the retiring op here even if a new op is captured.
      if (beat_done && (state_reg == ST_LO)) begin
        lo_q <= z_reg[DATA_W-1:0];
      end
      if (beat_done && (state_reg == ST_HI)) begin
        hi_q <= z_reg[2*DATA_W-1:DATA_W];
      end

      if (final_beat) begin
        retired_cnt <= retired_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_writeback.sv
// tb_alu_result_writeback
//   Scoreboard bench: each accepted result pushes its expected beats; the
//   monitor pops and compares on every output handshake and tracks the
//   expected HI/LO/counter values from the expected beats.
module tb_alu_result_writeback;
  import alu_result_writeback_pkg::*;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        upper_err;
  logic [15:0] retired_cnt;

  always #5 clock = ~clock;

  alu_result_writeback_if #(.DATA_W(32)) bus ();

  alu_result_writeback dut (
    .clock       (clock),
    .clear       (clear),
    .bus         (bus),
    .hi_q        (hi_q),
    .lo_q        (lo_q),
    .upper_err   (upper_err),
    .retired_cnt (retired_cnt)
  );

  typedef struct packed {
    logic [1:0]  tag;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [15:0] exp_cnt = '0;
  bit          mon_en = 1'b0;
  bit          quiet = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Output monitor / scoreboard
  always @(negedge clock) begin : monitor
    beat_t e;
    if (mon_en && clear && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("beat_tag", {62'd0, bus.out_tag}, {62'd0, e.tag});
        check("beat_data", {32'd0, bus.out_data}, {32'd0, e.data});
        if (!quiet) $display("beat tag=%0d data=%08h", bus.out_tag, bus.out_data);
        case (e.tag)
          2'b01: exp_lo = e.data;
          2'b10: begin exp_hi = e.data; exp_cnt = exp_cnt + 16'd1; end
          default: exp_cnt = exp_cnt + 16'd1;
        endcase
      end
    end
  end

  // Present one result and return just after the edge that accepted it.
  task automatic send(input logic [4:0] op, input logic [63:0] z, output int stalls);
    beat_t b;
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.Z        = z;
    stalls       = 0;
    forever begin
      @(negedge clock);
      if (bus.in_ready) break;
      stalls++;
      if (stalls > 50) begin
        check("accept_timeout", 64'd1, 64'd0);
        bus.in_valid = 1'b0;
        return;
      end
    end
    if (op == ALU_OP_MUL || op == ALU_OP_DIV) begin
      b.tag = 2'b01; b.data = z[31:0];  exp_q.push_back(b);
      b.tag = 2'b10; b.data = z[63:32]; exp_q.push_back(b);
    end else begin
      b.tag = 2'b00; b.data = z[31:0];  exp_q.push_back(b);
    end
    @(posedge clock); #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !bus.out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout", 64'd1, 64'd0);
    @(posedge clock); #1;
  endtask

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s1, s2, s3, n;
    bus.in_valid  = 1'b0;
    bus.opcode    = '0;
    bus.Z         = '0;
    bus.out_ready = 1'b0;

    // Reset state
    clear = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_data",  {32'd0, bus.out_data},  64'd0);
    check("rst_out_tag",   {62'd0, bus.out_tag},   64'd0);
    check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    check("rst_hi",        {32'd0, hi_q},          64'd0);
    check("rst_lo",        {32'd0, lo_q},          64'd0);
    check("rst_err",       {63'd0, upper_err},     64'd0);
    check("rst_cnt",       {48'd0, retired_cnt},   64'd0);
    @(negedge clock) clear = 1'b1;
    mon_en = 1'b1;
    @(posedge clock); #1;

    // Reset mid-beat: MUL held under backpressure, then reset asserted
    send(ALU_OP_MUL, 64'h0000_0001_0000_0002, s1);
    idle();
    check("mid_out_valid", {63'd0, bus.out_valid}, 64'd1);
    check("mid_out_data",  {32'd0, bus.out_data},  64'h2);
    @(posedge clock); #2;
    clear = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    exp_q.delete();
    @(negedge clock) clear = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("mid_rst_hi",  {32'd0, hi_q},        64'd0);
    check("mid_rst_lo",  {32'd0, lo_q},        64'd0);
    check("mid_rst_cnt", {48'd0, retired_cnt}, 64'd0);

    // ADD: single beat, visible the cycle after accept
    bus.out_ready = 1'b1;
    send(ALU_OP_ADD, 64'h0000_0000_0000_0007, s1);
    check("add_lat_valid", {63'd0, bus.out_valid}, 64'd1);
    check("add_lat_tag",   {62'd0, bus.out_tag},   64'd0);
    check("add_lat_data",  {32'd0, bus.out_data},  64'd7);
    idle();
    drain();
    check("add_hi",  {32'd0, hi_q},        64'd0);
    check("add_lo",  {32'd0, lo_q},        64'd0);
    check("add_cnt", {48'd0, retired_cnt}, 64'd1);

    // DIV: LO beat then HI beat, not ready during LO
    send(ALU_OP_DIV, 64'h0000_0003_0000_0004, s1);
    check("div_in_ready_lo", {63'd0, bus.in_ready}, 64'd0);
    idle();
    drain();
    check("div_lo",  {32'd0, lo_q},        64'd4);
    check("div_hi",  {32'd0, hi_q},        64'd3);
    check("div_cnt", {48'd0, retired_cnt}, 64'd2);

    // Backpressure on a MUL LO beat
    bus.out_ready = 1'b0;
    send(ALU_OP_MUL, 64'hDEAD_BEEF_CAFE_F00D, s1);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_valid", {63'd0, bus.out_valid}, 64'd1);
      check("bp_data",  {32'd0, bus.out_data},  64'hCAFE_F00D);
      check("bp_tag",   {62'd0, bus.out_tag},   64'd1);
    end
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    drain();
    check("bp_lo",  {32'd0, lo_q},        64'hCAFE_F00D);
    check("bp_hi",  {32'd0, hi_q},        64'hDEAD_BEEF);
    check("bp_cnt", {48'd0, retired_cnt}, 64'd3);

    // Back-to-back ORs: no bubbles, never stalled
    send(ALU_OP_OR, 64'h0000_0000_1111_0001, s1);
    fork
      begin
        send(ALU_OP_OR, 64'h0000_0000_2222_0002, s2);
        send(ALU_OP_OR, 64'h0000_0000_3333_0003, s3);
        idle();
      end
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clock);
          check("b2b_valid",    {63'd0, bus.out_valid}, 64'd1);
          check("b2b_in_ready", {63'd0, bus.in_ready},  64'd1);
        end
      end
    join
    check("b2b_stall2", s2, 0);
    check("b2b_stall3", s3, 0);
    drain();
    check("b2b_cnt", {48'd0, retired_cnt}, 64'd6);

    // Upper-word error, sticky
    check("err_before", {63'd0, upper_err}, 64'd0);
    send(ALU_OP_AND, 64'h0000_0001_0000_0000, s1);
    idle();
    check("err_set", {63'd0, upper_err}, 64'd1);
    drain();
    send(ALU_OP_ADD, 64'h0000_0000_0000_0005, s1);
    idle();
    drain();
    check("err_sticky", {63'd0, upper_err}, 64'd1);
    check("err_cnt",    {48'd0, retired_cnt}, 64'd8);
    check("model_hi",   {32'd0, hi_q}, {32'd0, exp_hi});
    check("model_lo",   {32'd0, lo_q}, {32'd0, exp_lo});

    // Counter wrap: stream up to 65535 retirements, then one more
    quiet = 1'b1;
    n = 65535 - int'(exp_cnt);
    for (int i = 0; i < n; i++) begin
      send(ALU_OP_ADD, {32'd0, $urandom}, s1);
    end
    idle();
    drain();
    check("cnt_max", {48'd0, retired_cnt}, 64'hFFFF);
    send(ALU_OP_SUB, 64'h0000_0000_0000_0009, s1);
    idle();
    drain();
    quiet = 1'b0;
    check("cnt_wrap",      {48'd0, retired_cnt}, 64'd0);
    check("cnt_model",     {48'd0, retired_cnt}, {48'd0, exp_cnt});
    check("err_still_set", {63'd0, upper_err},   64'd1);
    check("final_hi",      {32'd0, hi_q},        64'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_writeback.md
Name: alu_result_writeback

Overview:
- Sits directly downstream of the datapath ALU. Consumes its 64-bit Z result and the opcode that produced it.
- Registers the result into the Z register and retires it onto the 32-bit datapath bus through a valid/ready handshake.
- Single-word ops take one beat. Multiply and divide take two beats (LO, then HI) and also update the architectural HI/LO registers.
- Exposes a sticky upper-word error flag and a retired-operation counter for debug.

Parameters:
- DATA_W, 32, bus word width; Z is 2*DATA_W.
- CNT_W, 16, width of retired-operation counter.
- OP_MUL, 5'b01111, opcode that produces a 64-bit result.
- OP_DIV, 5'b10000, opcode that produces a 64-bit result (LO = quotient, HI = remainder).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  ALU result presented.
- in_ready  out  1  block can accept a result this cycle.
- opcode  in  5  opcode that produced Z.
- Z  in  64  ALU result.
- out_valid  out  1  bus beat presented.
- out_ready  in  1  bus consumer accepts the beat.
- out_data  out  32  beat payload.
- out_tag  out  2  beat destination: 2'b00 = Rz (general register), 2'b01 = LO, 2'b10 = HI.
- hi_q  out  32  HI register.
- lo_q  out  32  LO register.
- upper_err  out  1  sticky: non-mul/div op arrived with Z[63:32] != 0.
- retired_cnt  out  CNT_W  count of fully retired operations.

Behaviour:
- Reset: while clear=0, asynchronously force the following:
  - state=IDLE, out_valid=0, out_data=0, out_tag=0.
  - hi_q=0, lo_q=0, upper_err=0, retired_cnt=0, internal Z register=0.
  - Any in-flight operation is dropped; nothing is retired for it.
- FSM states: IDLE, ONE (single beat), LO (first of two), HI (second of two).
- Accept condition: in_valid & in_ready.
  - On accept, capture Z and opcode.
  - Next state is LO if opcode is OP_MUL or OP_DIV, otherwise ONE. Unknown opcodes are treated as single-word.
- in_ready = (state==IDLE) | ((state==ONE | state==HI) & out_ready). This is combinational from out_ready, so back-to-back retirement is possible.
- Latency: accept at edge N gives out_valid=1 from cycle N+1.
- Throughput:
  - One single-word op per cycle while out_ready stays high.
  - One mul/div per two cycles.
- Beats:
  - ONE: out_data=Z[31:0], out_tag=00.
  - LO: out_data=Z[31:0], out_tag=01.
  - HI: out_data=Z[63:32], out_tag=10.
- Output stability: out_valid, out_data and out_tag are registered and must stay stable while out_valid & !out_ready. No beat may be skipped or duplicated.
- Transitions:
  - ONE --handshake--> IDLE, or straight to the next captured op if a new accept happens in the same cycle.
  - LO --handshake--> HI.
  - HI --handshake--> IDLE, or the next op as above.
- HI/LO update:
  - lo_q <= Z[31:0] on the LO handshake.
  - hi_q <= Z[63:32] on the HI handshake.
  - Single-word ops never touch hi_q or lo_q.
- upper_err: set on accept of a non-mul/div op with Z[63:32]!=0. Cleared only by reset.
- retired_cnt: increments on the ONE handshake and on the HI handshake. Wraps modulo 2^CNT_W with no saturation.
- Simultaneous events:
  - Final-beat handshake and new accept in the same cycle: load the new op, keep out_valid=1, present the new op's first beat.
  - retired_cnt still increments for the retiring op.
- in_valid while not ready: the input is ignored. The upstream must hold its result; nothing is latched.

Decomposition:
- Shared package: the opcode constants (full ALU opcode list, including OP_MUL and OP_DIV), the out_tag encodings, and the FSM state encoding.
- Single module; no sub-module needed. The beat mux and FSM are small enough to stay flat.

Test Plan:
- Reset mid-beat:
  - Stimulus: accept MUL with Z=64'h0000_0001_0000_0002, stall out_ready=0, assert clear=0.
  - Required: out_valid=0 immediately; hi_q=lo_q=0 and retired_cnt=0 after release.
- ADD result:
  - Stimulus: opcode=00011, Z=64'h0000_0000_0000_0007, out_ready=1.
  - Required: one beat, out_tag=00, out_data=7, cycle N+1; hi_q and lo_q unchanged; retired_cnt=1.
- DIV result:
  - Stimulus: opcode=10000, Z=64'h0000_0003_0000_0004, out_ready=1.
  - Required: beats (01, 0x4) then (10, 0x3); lo_q=4; hi_q=3; in_ready low during LO.
- Backpressure:
  - Stimulus: MUL Z=64'hDEAD_BEEF_CAFE_F00D, out_ready=0 for 3 cycles, then 1.
  - Required: out_data holds 0xCAFEF00D, tag 01, for all stalled cycles; HI beat follows.
- Back-to-back:
  - Stimulus: three ORs presented on consecutive cycles with out_ready=1.
  - Required: three consecutive beats, no bubbles, in_ready=1 throughout; retired_cnt=3.
- Upper error and counter wrap:
  - Stimulus: AND with Z[63:32]=1.
  - Required: upper_err=1 and stays set.
  - Stimulus: preload to 65535 retirements, then retire one more.
  - Required: retired_cnt=0.
